// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single slave port.
// One transaction at a time: IDLE grants, XFER waits for s_ack or the watchdog.
module mem_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_done,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_done,
  output logic          m1_err,
  output logic [DW-1:0] rdata,
  output logic          s_en,
  output logic          s_we,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_ack,
  output logic          dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t        state_q;
  logic          last_gnt_q;
  logic          owner_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          m0_gnt_q, m0_done_q, m0_err_q;
  logic          m1_gnt_q, m1_done_q, m1_err_q;
  logic [DW-1:0] rdata_q;
  logic          s_en_q, s_we_q;
  logic [AW-1:0] s_addr_q;
  logic [DW-1:0] s_wdata_q;

  logic          grant_any;
  logic          grant_sel;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          timeout_hit;

  // On a tie the master that did not win last time is picked.
  always_comb begin
    grant_any = m0_req | m1_req;
    if (m0_req && m1_req) begin
      grant_sel = ~last_gnt_q;
    end else begin
      grant_sel = m1_req;
    end
    sel_we      = grant_sel ? m1_we    : m0_we;
    sel_addr    = grant_sel ? m1_addr  : m0_addr;
    sel_wdata   = grant_sel ? m1_wdata : m0_wdata;
    timeout_hit = (count_q == CW'(TIMEOUT - 1));
    count_d     = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      owner_q    <= 1'b0;
      count_q    <= '0;
      m0_gnt_q   <= 1'b0;
      m0_done_q  <= 1'b0;
      m0_err_q   <= 1'b0;
      m1_gnt_q   <= 1'b0;
      m1_done_q  <= 1'b0;
      m1_err_q   <= 1'b0;
      rdata_q    <= '0;
      s_en_q     <= 1'b0;
      s_we_q     <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
    end else begin
      m0_done_q <= 1'b0;
      m0_err_q  <= 1'b0;
      m1_done_q <= 1'b0;
      m1_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            owner_q   <= grant_sel;
            s_we_q    <= sel_we;
            s_addr_q  <= sel_addr;
            s_wdata_q <= sel_wdata;
            s_en_q    <= 1'b1;
            m0_gnt_q  <= ~grant_sel;
            m1_gnt_q  <= grant_sel;
            count_q   <= '0;
            state_q   <= XFER;
          end
        end
        XFER: begin
          // An ack arriving on the last watchdog cycle still counts as success.
          if (s_ack || timeout_hit) begin
            m0_done_q  <= ~owner_q;
            m1_done_q  <= owner_q;
            m0_err_q   <= ~s_ack & ~owner_q;
            m1_err_q   <= ~s_ack & owner_q;
            rdata_q    <= (s_ack && !s_we_q) ? s_rdata : '0;
            last_gnt_q <= owner_q;
            s_en_q     <= 1'b0;
            m0_gnt_q   <= 1'b0;
            m1_gnt_q   <= 1'b0;
            state_q    <= IDLE;
          end else begin
            count_q <= count_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_gnt    = m0_gnt_q;
  assign m0_done   = m0_done_q;
  assign m0_err    = m0_err_q;
  assign m1_gnt    = m1_gnt_q;
  assign m1_done   = m1_done_q;
  assign m1_err    = m1_err_q;
  assign rdata     = rdata_q;
  assign s_en      = s_en_q;
  assign s_we      = s_we_q;
  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: vector table of single transactions plus
// hand-written contention, timeout race and mid-transfer reset sequences.
module tb_mem_bus_arbiter;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [31:0] rdata, s_addr, s_wdata, s_rdata;
  logic        s_en, s_we, s_ack, dbg_state;

  int total = 0;
  int bad   = 0;

  // Expected completion record: {master, err, rdata}.
  logic [33:0] exp_q[$];

  typedef struct {
    logic        m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] srd;
    int          ack_cyc;
    int          exp_len;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[6];

  mem_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err),
    .rdata(rdata), .s_en(s_en), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench timed out");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic set_req(input logic m, input logic v, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (m) begin
      m1_req = v; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = v; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end
  endtask

  task automatic drop_req(input logic m);
    if (m) m1_req = 1'b0;
    else   m0_req = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    int n;
    int len;
    set_req(v.m, 1'b1, v.we, v.addr, v.wdata);
    exp_q.push_back({v.m, v.exp_err, v.exp_rdata});
    n = 0;
    tick();
    while (!s_en && n < 8) begin
      tick();
      n++;
    end
    check("grant_seen", 64'(s_en), 64'(1));
    check("gnt_owner", 64'({m1_gnt, m0_gnt}), v.m ? 64'(2'b10) : 64'(2'b01));
    check("s_addr", 64'(s_addr), 64'(v.addr));
    check("s_we", 64'(s_we), 64'(v.we));
    check("s_wdata", 64'(s_wdata), 64'(v.wdata));
    // Releasing req mid-transfer must not cancel the access.
    drop_req(v.m);
    len = 0;
    for (int c = 1; c <= TIMEOUT + 2; c++) begin
      if (c == v.ack_cyc) begin
        s_ack = 1'b1;
        s_rdata = v.srd;
      end
      tick();
      s_ack = 1'b0;
      s_rdata = $urandom;
      len = c;
      if (!s_en) break;
    end
    check("xfer_len", 64'(len), 64'(v.exp_len));
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [33:0] e;
    logic [33:0] got;
    if (rst_n === 1'b1) begin
      total++;
      if (m0_gnt && m1_gnt) begin
        bad++;
        $display("FAIL gnt_excl: got both granted want one");
      end
      if (m0_done || m1_done) begin
        total++;
        got = {m1_done, (m1_done ? m1_err : m0_err), rdata};
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done: got %0h want none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e || (m0_done && m1_done)) begin
            bad++;
            $display("FAIL done_rec: got %0h want %0h", got, e);
          end
        end
      end else if (m0_err || m1_err) begin
        total++;
        bad++;
        $display("FAIL err_no_done: got err want no err");
      end
    end
  end

  initial begin
    vec_t v;
    tbl[0] = '{1'b0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0BAD_0BAD, 2,  2,  1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 32'h0000_2004, 32'h0,         32'h1234_5678, 3,  3,  1'b0, 32'h1234_5678};
    tbl[2] = '{1'b0, 1'b0, 32'h0000_3000, 32'h0,         32'hA5A5_A5A5, 1,  1,  1'b0, 32'hA5A5_A5A5};
    tbl[3] = '{1'b0, 1'b0, 32'h0000_4000, 32'h0,         32'h5555_AAAA, 0,  16, 1'b1, 32'h0};
    tbl[4] = '{1'b1, 1'b0, 32'h0000_5000, 32'h0,         32'hCAFE_F00D, 16, 16, 1'b0, 32'hCAFE_F00D};
    tbl[5] = '{1'b1, 1'b1, 32'h0000_6008, 32'h1122_3344, 32'hFFFF_FFFF, 1,  1,  1'b0, 32'h0};

    rst_n = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    s_ack = 0; s_rdata = 0;
    tick();
    tick();
    check("rst_ctrl", 64'({m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err, s_en, s_we, dbg_state}), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_s_addr", 64'(s_addr), 64'(0));
    check("rst_s_wdata", 64'(s_wdata), 64'(0));
    rst_n = 1'b1;
    tick();

    // A stray ack while idle must be ignored.
    s_ack = 1'b1;
    s_rdata = 32'h9999_9999;
    tick();
    tick();
    s_ack = 1'b0;
    check("idle_ack_s_en", 64'({s_en, dbg_state}), 64'(0));

    for (int i = 0; i < 6; i++) run_txn(tbl[i]);

    for (int i = 0; i < 4; i++) begin
      v.m       = 1'($urandom_range(0, 1));
      v.we      = 1'($urandom_range(0, 1));
      v.addr    = $urandom;
      v.wdata   = $urandom;
      v.srd     = $urandom;
      v.ack_cyc = $urandom_range(1, 4);
      v.exp_len = v.ack_cyc;
      v.exp_err = 1'b0;
      v.exp_rdata = v.we ? 32'h0 : v.srd;
      run_txn(v);
    end

    // Contention from reset: both hold req, slave acks at once.
    do_reset();
    s_ack = 1'b1;
    s_rdata = 32'h0000_0077;
    set_req(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
    for (int i = 0; i < 4; i++) exp_q.push_back({1'(i % 2), 1'b0, 32'h0000_0077});
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("rr_s_en", 64'(s_en), 64'(k % 2));
      if (k % 2 == 1) check("rr_owner", 64'({m1_gnt, m0_gnt}), ((k / 2) % 2 == 1) ? 64'(2'b10) : 64'(2'b01));
    end
    drop_req(1'b0);
    drop_req(1'b1);
    s_ack = 1'b0;
    tick();

    // m0 completes, so last winner is m0 going into the mid-transfer reset.
    v = '{1'b0, 1'b1, 32'h0000_7000, 32'h0000_0042, 32'h0, 1, 1, 1'b0, 32'h0};
    run_txn(v);
    set_req(1'b0, 1'b1, 1'b0, 32'h0000_8000, 32'h0);
    tick();
    check("mid_s_en_up", 64'(s_en), 64'(1));
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_drop", 64'({s_en, m0_gnt, m1_gnt}), 64'(0));
    drop_req(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    set_req(1'b0, 1'b1, 1'b0, 32'h0000_9000, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 32'h0000_A000, 32'h0);
    tick();
    check("post_rst_tie", 64'({m1_gnt, m0_gnt}), 64'(2'b01));
    check("post_rst_addr", 64'(s_addr), 64'(32'h0000_9000));
    exp_q.push_back({1'b0, 1'b0, 32'hBEEF_0001});
    s_ack = 1'b1;
    s_rdata = 32'hBEEF_0001;
    drop_req(1'b0);
    drop_req(1'b1);
    tick();
    s_ack = 1'b0;
    tick();
    tick();

    check("exp_q_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
